// File: rtl/picosoc_iomem_timer.sv
// rtl/picosoc_iomem_timer.sv - memory-mapped 32-bit timer/compare peripheral on the iomem bus
//
// Purpose: free-running 32-bit counter, advanced by a programmable prescaler,
// with a compare register that sets a sticky match flag. The match flag,
// qualified by CTRL.irq_en, drives the irq output.
//
// Ports:
//   clk          clock
//   resetn       synchronous, active-low reset
//   iomem_valid  bus request
//   iomem_ready  one-cycle access-complete pulse (registered)
//   iomem_wstrb  byte write strobes, 0 = read
//   iomem_addr   byte address
//   iomem_wdata  write data
//   iomem_rdata  read data, nonzero only while iomem_ready=1
//   irq          level interrupt = STATUS.match & CTRL.irq_en
//
// Register map (word offsets, addr[1:0] ignored):
//   0x00 CTRL      [0] en, [1] auto_reload, [2] irq_en
//   0x04 PRESCALE  [PRESCALE_W-1:0]
//   0x08 COUNT     32-bit
//   0x0C COMPARE   32-bit
//   0x10 STATUS    [0] match, write-1-to-clear
//   0x14-0x1C      read 0, writes ignored

module picosoc_iomem_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_COMPARE  = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;

  logic [2:0]            ctrl_q;       // {irq_en, auto_reload, en}
  logic [PRESCALE_W-1:0] prescale_q;
  logic [PRESCALE_W-1:0] pre_cnt_q;
  logic [31:0]           count_q;
  logic [31:0]           compare_q;
  logic                  match_q;

  logic        sel;
  logic        access;
  logic        wr;
  logic [2:0]  reg_idx;
  logic [31:0] wmask;
  logic        wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
  logic        tick;
  logic        hit;
  logic        status_clr;
  logic [31:0] read_mux;
  logic        unused_addr_bits;

  assign sel     = iomem_valid && (iomem_addr[31:5] == BASE_ADDR[31:5]);
  // The registered ready blocks a second access on the cycle after a pulse,
  // which is what makes the response exactly one cycle long.
  assign access  = sel && !iomem_ready;
  assign wr      = access && (iomem_wstrb != 4'b0000);
  assign reg_idx = iomem_addr[4:2];
  assign unused_addr_bits = &{1'b0, iomem_addr[1:0]};

  assign wmask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                  {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};

  assign wr_ctrl     = wr && (reg_idx == REG_CTRL);
  assign wr_prescale = wr && (reg_idx == REG_PRESCALE);
  assign wr_count    = wr && (reg_idx == REG_COUNT);
  assign wr_compare  = wr && (reg_idx == REG_COMPARE);
  assign wr_status   = wr && (reg_idx == REG_STATUS);

  assign tick       = ctrl_q[0] && (pre_cnt_q == prescale_q);
  // A bus write to COUNT swallows the tick on that edge, including its match.
  assign hit        = tick && !wr_count && (count_q == compare_q);
  assign status_clr = wr_status && iomem_wstrb[0] && iomem_wdata[0];

  assign irq = match_q && ctrl_q[2];

  always_comb begin
    read_mux = 32'h0;
    case (reg_idx)
      REG_CTRL:     read_mux = {29'h0, ctrl_q};
      REG_PRESCALE: read_mux = 32'(prescale_q);
      REG_COUNT:    read_mux = count_q;
      REG_COMPARE:  read_mux = compare_q;
      REG_STATUS:   read_mux = {31'h0, match_q};
      default:      read_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'h0;
      ctrl_q      <= 3'b000;
      prescale_q  <= '0;
      pre_cnt_q   <= '0;
      count_q     <= 32'h0;
      compare_q   <= 32'h0;
      match_q     <= 1'b0;
    end else begin
      iomem_ready <= access;
      iomem_rdata <= access ? read_mux : 32'h0;

      if (wr_ctrl && iomem_wstrb[0]) begin
        ctrl_q <= iomem_wdata[2:0];
      end

      if (wr_prescale) begin
        prescale_q <= (prescale_q & ~wmask[PRESCALE_W-1:0])
                    | (iomem_wdata[PRESCALE_W-1:0] & wmask[PRESCALE_W-1:0]);
      end

      // Disabled or freshly reprogrammed prescaler restarts from zero.
      if (!ctrl_q[0] || wr_prescale || tick) begin
        pre_cnt_q <= '0;
      end else begin
        pre_cnt_q <= pre_cnt_q + PRESCALE_W'(1);
      end

      if (wr_count) begin
        count_q <= (count_q & ~wmask) | (iomem_wdata & wmask);
      end else if (tick) begin
        if ((count_q == compare_q) && ctrl_q[1]) begin
          count_q <= 32'h0;
        end else begin
          count_q <= count_q + 32'd1;
        end
      end

      if (wr_compare) begin
        compare_q <= (compare_q & ~wmask) | (iomem_wdata & wmask);
      end

      // A new match beats a simultaneous write-1-to-clear.
      if (hit) begin
        match_q <= 1'b1;
      end else if (status_clr) begin
        match_q <= 1'b0;
      end
    end
  end

endmodule
